ucore_state_trace: RTL and testbench

- Observer and decoder for the state register of a generated microcode core.
- Samples the core's 12-bit `_current_state_` encoding every cycle and detects block transitions.
- Pushes one trace entry per transition (new state plus cycles spent in the previous state) into a FIFO.
- A host or debug bus drains the FIFO through a valid/ready interface. The block is the read side of the core's state sequence and is used for program-flow debug and coverage collection.

---
 rtl/ucore_state_trace.sv | 183 ++++++++++++++++++
 tb/tb_ucore_state_trace.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ucore_state_trace.sv
// ucore_state_trace: watches a microcode core's state register, logs one entry
// per state transition (new state, cycles held in the previous state, lost flag)
// into a FIFO that a host drains through a valid/ready handshake.
// Optional feature macro: UCORE_TRACE_TIMESTAMP_EN enables the hold-cycle counter
// and the delta field; when undefined, trace_delta is tied to 0.
module ucore_state_trace #(
   parameter int STATE_W = 12,
   parameter int DEPTH   = 16,
   parameter int TS_W    = 16
) (
   input  logic                   clk,
   input  logic                   aresetn,
   input  logic                   trace_en,
   input  logic                   flush,
   input  logic [STATE_W-1:0]     core_state,
   output logic                   trace_valid,
   input  logic                   trace_ready,
   output logic [STATE_W-1:0]     trace_state,
   output logic [TS_W-1:0]        trace_delta,
   output logic                   trace_lost,
   output logic [$clog2(DEPTH):0] fifo_level,
   output logic [7:0]             drop_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

`ifdef UCORE_TRACE_TIMESTAMP_EN
   typedef struct packed {
      logic              lost;
      logic [TS_W-1:0]   delta;
      logic [STATE_W-1:0] state;
   } entry_t;
`else
   typedef struct packed {
      logic               lost;
      logic [STATE_W-1:0] state;
   } entry_t;
`endif

   entry_t             mem_q [DEPTH];
   entry_t             wr_entry;
   entry_t             head;

   logic [STATE_W-1:0] prev_q, prev_d;
   logic               primed_q, primed_d;
   logic               lost_pend_q, lost_pend_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [7:0]         drop_q, drop_d;
`ifdef UCORE_TRACE_TIMESTAMP_EN
   logic [TS_W-1:0]    hold_q, hold_d;
   logic [TS_W-1:0]    hold_inc;
`endif

   logic fifo_empty, fifo_full;
   logic evt, pop, push, drop;

   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LVL_W'(DEPTH));
   // A transition is any state change, or the first sample after enable/flush/reset.
   assign evt  = trace_en && (!primed_q || (core_state != prev_q));
   assign pop  = !fifo_empty && trace_ready;
   // A full FIFO still accepts when the head leaves on the same edge.
   assign push = evt && (!fifo_full || pop);
   assign drop = evt && fifo_full && !pop;

`ifdef UCORE_TRACE_TIMESTAMP_EN
   // Saturating increment shared by the hold counter and the delta field.
   assign hold_inc = (hold_q == '1) ? hold_q : hold_q + TS_W'(1);
`endif

   // Assemble the entry that an event would write.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      wr_entry       = '0;
      wr_entry.state = core_state;
      wr_entry.lost  = lost_pend_q;
`ifdef UCORE_TRACE_TIMESTAMP_EN
      wr_entry.delta = primed_q ? hold_inc : '0;
`endif
   end

   // Next-state for tracking, pointers, level and drop counter; flush overrides all.
   always_comb begin
      prev_d      = prev_q;
      primed_d    = primed_q;
      lost_pend_d = lost_pend_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      drop_d      = drop_q;
`ifdef UCORE_TRACE_TIMESTAMP_EN
      hold_d      = hold_q;
`endif
      if (flush) begin
         primed_d    = 1'b0;
         lost_pend_d = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         drop_d      = '0;
`ifdef UCORE_TRACE_TIMESTAMP_EN
         hold_d      = '0;
`endif
      end else begin
         if (!trace_en) begin
            primed_d = 1'b0;
         end else if (evt) begin
            prev_d   = core_state;
            primed_d = 1'b1;
`ifdef UCORE_TRACE_TIMESTAMP_EN
            hold_d   = '0;
         end else begin
            hold_d   = hold_inc;
`endif
         end
         if (push) begin
            wr_ptr_d    = wr_ptr_q + PTR_W'(1);
            lost_pend_d = 1'b0;
         end
         if (drop) begin
            lost_pend_d = 1'b1;
            if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
         end
         if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
      end
   end

   // Control and tracking registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         prev_q      <= '0;
         primed_q    <= 1'b0;
         lost_pend_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         drop_q      <= '0;
`ifdef UCORE_TRACE_TIMESTAMP_EN
         hold_q      <= '0;
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         prev_q      <= prev_d;
         primed_q    <= primed_d;
         lost_pend_q <= lost_pend_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         drop_q      <= drop_d;
`ifdef UCORE_TRACE_TIMESTAMP_EN
         hold_q      <= hold_d;
`endif
      end
   end

   // Entry storage write.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the level counter alone decides which slots are valid.
      if (push && !flush) mem_q[wr_ptr_q] <= wr_entry;
   end

   // Head entry is masked so the outputs read 0 instead of stale or unwritten storage when empty.
   assign head        = mem_q[rd_ptr_q];
   assign trace_valid = !fifo_empty;
   assign trace_state = trace_valid ? head.state : '0;
   assign trace_lost  = trace_valid ? head.lost  : 1'b0;
`ifdef UCORE_TRACE_TIMESTAMP_EN
   assign trace_delta = trace_valid ? head.delta : '0;
`else
   assign trace_delta = '0;
`endif
   assign fifo_level  = level_q;
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_ucore_state_trace.sv
// Directed bench for ucore_state_trace: expected entries are queued as each
// transition is driven and compared when the host pops the FIFO head.
module tb_ucore_state_trace;

   logic        clk;
   logic        aresetn;
   logic        trace_en;
   logic        flush;
   logic [11:0] core_state;
   logic        trace_valid;
   logic        trace_ready;
   logic [11:0] trace_state;
   logic [15:0] trace_delta;
   logic        trace_lost;
   logic [4:0]  fifo_level;
   logic [7:0]  drop_count;

`ifdef UCORE_TRACE_TIMESTAMP_EN
   localparam bit TS_ON = 1'b1;
`else
   localparam bit TS_ON = 1'b0;
`endif

   typedef struct {
      logic [11:0] st;
      logic [15:0] d;
      logic        l;
   } exp_t;

   exp_t sb[$];
   int   n_asserts = 0;
   int   n_fail    = 0;

   ucore_state_trace dut (
      .clk         (clk),
      .aresetn     (aresetn),
      .trace_en    (trace_en),
      .flush       (flush),
      .core_state  (core_state),
      .trace_valid (trace_valid),
      .trace_ready (trace_ready),
      .trace_state (trace_state),
      .trace_delta (trace_delta),
      .trace_lost  (trace_lost),
      .fifo_level  (fifo_level),
      .drop_count  (drop_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input logic [11:0] st, input logic [15:0] d, input logic l);
      exp_t e;
      e.st = st;
      e.d  = TS_ON ? d : 16'd0;
      e.l  = l;
      sb.push_back(e);
   endtask

   // One clock cycle: drive inputs, score a pop if one happens on this edge, advance.
   task automatic cyc(input logic [11:0] st, input logic en, input logic rdy, input logic fl);
      exp_t e;
      core_state  = st;
      trace_en    = en;
      trace_ready = rdy;
      flush       = fl;
      if (trace_valid && trace_ready && !fl) begin
         check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("trace_state", 32'(trace_state), 32'(e.st));
            check("trace_delta", 32'(trace_delta), 32'(e.d));
            check("trace_lost",  32'(trace_lost),  32'(e.l));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input logic [11:0] st);
      int n = 0;
      while (trace_valid && n < 40) begin
         cyc(st, 1'b1, 1'b1, 1'b0);
         n++;
      end
      check("drain_done", 32'(trace_valid), 32'd0);
      check("sb_empty",   32'(sb.size()),   32'd0);
   endtask

   initial begin
      aresetn     = 1'b0;
      trace_en    = 1'b0;
      flush       = 1'b0;
      core_state  = '0;
      trace_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(trace_valid), 32'd0);
      check("rst_level", 32'(fifo_level),  32'd0);
      check("rst_drop",  32'(drop_count),  32'd0);
      check("rst_state", 32'(trace_state), 32'd0);
      check("rst_delta", 32'(trace_delta), 32'd0);
      check("rst_lost",  32'(trace_lost),  32'd0);
      aresetn = 1'b1;

      // Basic capture: 5 held for three edges, then 9; one-cycle write latency.
      cyc(12'd0, 1'b0, 1'b0, 1'b0);
      check("t1_valid_pre", 32'(trace_valid), 32'd0);
      sb_push(12'd5, 16'd0, 1'b0);
      cyc(12'd5, 1'b1, 1'b0, 1'b0);
      check("t1_valid_rise", 32'(trace_valid), 32'd1);
      check("t1_level1",     32'(fifo_level),  32'd1);
      cyc(12'd5, 1'b1, 1'b0, 1'b0);
      cyc(12'd5, 1'b1, 1'b0, 1'b0);
      check("t1_head_stable", 32'(trace_state), 32'd5);
      sb_push(12'd9, 16'd3, 1'b0);
      cyc(12'd9, 1'b1, 1'b0, 1'b0);
      check("t1_level2", 32'(fifo_level), 32'd2);
      drain(12'd9);

      // Disable while the state moves 3 -> 4; FIFO keeps draining; re-enable logs delta 0.
      cyc(12'd2, 1'b1, 1'b0, 1'b1);
      sb_push(12'd2, 16'd0, 1'b0);
      cyc(12'd2, 1'b1, 1'b0, 1'b0);
      cyc(12'd2, 1'b1, 1'b0, 1'b0);
      sb_push(12'd6, 16'd2, 1'b0);
      cyc(12'd6, 1'b1, 1'b0, 1'b0);
      sb_push(12'd3, 16'd1, 1'b0);
      cyc(12'd3, 1'b1, 1'b0, 1'b0);
      cyc(12'd3, 1'b1, 1'b0, 1'b0);
      check("t5_level3", 32'(fifo_level), 32'd3);
      cyc(12'd3, 1'b0, 1'b1, 1'b0);
      cyc(12'd3, 1'b0, 1'b1, 1'b0);
      cyc(12'd4, 1'b0, 1'b1, 1'b0);
      cyc(12'd4, 1'b0, 1'b1, 1'b0);
      cyc(12'd4, 1'b0, 1'b1, 1'b0);
      check("t5_no_entries_disabled", 32'(fifo_level), 32'd0);
      sb_push(12'd4, 16'd0, 1'b0);
      cyc(12'd4, 1'b1, 1'b0, 1'b0);
      check("t5_reenable_level", 32'(fifo_level), 32'd1);
      drain(12'd4);

      // Overflow: 20 alternating transitions into a 16-deep FIFO.
      cyc(12'd1, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 20; i++) begin
         logic [11:0] st;
         st = (i % 2 == 0) ? 12'd1 : 12'd2;
         if (i == 0)      sb_push(st, 16'd0, 1'b0);
         else if (i < 16) sb_push(st, 16'd1, 1'b0);
         cyc(st, 1'b1, 1'b0, 1'b0);
      end
      check("t2_level_full", 32'(fifo_level), 32'd16);
      check("t2_drop4",      32'(drop_count), 32'd4);
      drain(12'd2);
      // State 2 was last seen at the final dropped event plus 16 drain edges.
      sb_push(12'd1, 16'd17, 1'b1);
      cyc(12'd1, 1'b1, 1'b0, 1'b0);
      sb_push(12'd2, 16'd1, 1'b0);
      cyc(12'd2, 1'b1, 1'b0, 1'b0);
      check("t2_drop_hold", 32'(drop_count), 32'd4);
      drain(12'd2);

      // Full FIFO with simultaneous pop and event: accepted, level and drop count unchanged.
      cyc(12'd2, 1'b1, 1'b0, 1'b1);
      check("t3_flush_drop", 32'(drop_count), 32'd0);
      for (int i = 0; i < 17; i++) begin
         logic [11:0] st;
         st = (i % 2 == 0) ? 12'd1 : 12'd2;
         if (i == 0)      sb_push(st, 16'd0, 1'b0);
         else if (i < 16) sb_push(st, 16'd1, 1'b0);
         cyc(st, 1'b1, 1'b0, 1'b0);
      end
      check("t3_level_full", 32'(fifo_level), 32'd16);
      check("t3_drop1",      32'(drop_count), 32'd1);
      sb_push(12'd2, 16'd1, 1'b1);
      cyc(12'd2, 1'b1, 1'b1, 1'b0);
      check("t3_level_same", 32'(fifo_level), 32'd16);
      check("t3_drop_same",  32'(drop_count), 32'd1);
      drain(12'd2);

      // Flush at level 6 with a coincident event.
      for (int i = 0; i < 6; i++) cyc(12'(3 + i), 1'b1, 1'b0, 1'b0);
      check("t6_level6", 32'(fifo_level), 32'd6);
      cyc(12'd9, 1'b1, 1'b0, 1'b1);
      check("t6_flush_level", 32'(fifo_level),  32'd0);
      check("t6_flush_valid", 32'(trace_valid), 32'd0);
      check("t6_flush_drop",  32'(drop_count),  32'd0);
      sb_push(12'd9, 16'd0, 1'b0);
      cyc(12'd9, 1'b1, 1'b0, 1'b0);
      check("t6_next_level", 32'(fifo_level), 32'd1);
      drain(12'd9);

      // Hold counter saturation: state 7 held for 70000 edges, then 8.
      cyc(12'd7, 1'b1, 1'b0, 1'b1);
      sb_push(12'd7, 16'd0, 1'b0);
      for (int i = 0; i < 70000; i++) cyc(12'd7, 1'b1, 1'b1, 1'b0);
      sb_push(12'd8, 16'hFFFF, 1'b0);
      cyc(12'd8, 1'b1, 1'b1, 1'b0);
      drain(12'd8);

      // Asynchronous reset mid-operation discards entries immediately.
      cyc(12'd5, 1'b1, 1'b0, 1'b0);
      cyc(12'd6, 1'b1, 1'b0, 1'b0);
      check("ar_level_pre", 32'(fifo_level), 32'd2);
      #2 aresetn = 1'b0;
      #1;
      check("ar_level",  32'(fifo_level),  32'd0);
      check("ar_valid",  32'(trace_valid), 32'd0);
      check("ar_state",  32'(trace_state), 32'd0);
      @(posedge clk);
      #1 aresetn = 1'b1;
      sb_push(12'd5, 16'd0, 1'b0);
      cyc(12'd5, 1'b1, 1'b0, 1'b0);
      check("ar_next_level", 32'(fifo_level), 32'd1);
      drain(12'd5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
